// File: rtl/i2c_pkg.sv
// Shared types for the I2C master: FSM states, quarter-slot index and the
// quarter-period divider calculation.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, STA, ADR, W1, W2, RD, STO} state_e;

  typedef logic [1:0] qtr_t;

  function automatic int calc_div(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-bit divider: counts 0..DIV-1 while enabled and pulses wrap_o on the
// last count; held at zero when disabled.
module i2c_qtick #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic wrap_o
);

  localparam int CW = $clog2(DIV);

  if (DIV < 2) begin : g_div_chk
    $error("i2c_qtick: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q;

  assign wrap_o = en_i && (cnt_q == CW'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i || wrap_o) cnt_q <= '0;
    else                            cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/i2c_master.sv
// Single-transaction I2C master: START, address, one/two write bytes or one
// read byte, STOP. END/ACK form a level handshake for the upstream sequencer.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int CLK_Freq = 50_000_000,
  parameter int I2C_Freq = 20_000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  output logic       I2C_SCL,
  inout  wire        I2C_SDA,
  input  logic [6:0] I2C_ADDR,
  input  logic       I2C_WLEN,
  input  logic [7:0] I2C_WDATA1,
  input  logic [7:0] I2C_WDATA2,
  input  logic       READ,
  input  logic       START,
  output logic       END,
  output logic       ACK,
  output logic [7:0] I2C_RDATA
);

  localparam int DIV = calc_div(CLK_Freq, I2C_Freq);

  state_e     state_q, state_d;
  qtr_t       qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d, rx_q, rdata_q, rdata_d;
  logic       pend_q, nack_q, scl_q, sda_low_q;
  logic       end_q, end_d, ack_q, ack_d;
  logic [6:0] addr_q;
  logic [7:0] wd1_q, wd2_q;
  logic       wlen_q, read_q;
  logic       wrap, accept;

  i2c_qtick #(.DIV(DIV)) u_qtick (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .en_i   (state_q != IDLE),
    .wrap_o (wrap)
  );

  // Request is registered first, so the bus sequence starts one cycle later.
  assign accept = (state_q == IDLE) && !pend_q && START;

  // Returns {scl, sda_low} for the quarter about to begin.
  function automatic logic [1:0] bus_drive(input state_e s, input qtr_t q,
                                           input logic [3:0] b, input logic txb);
    case (s)
      STA:         return {q != 2'd3, q != 2'd0};
      STO:         return {q != 2'd0, !q[1]};
      ADR, W1, W2: return {q[1], (b < 4'd8) && !txb};
      RD:          return {q[1], 1'b0};
      default:     return 2'b10;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    end_d   = end_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    if (state_q == IDLE) begin
      if (pend_q) begin
        state_d = STA;
        qtr_d   = '0;
        bit_d   = '0;
        end_d   = 1'b0;
        ack_d   = 1'b0;
      end
    end else if (wrap) begin
      qtr_d = qtr_q + 2'd1;
      if (qtr_q == 2'd3) begin
        bit_d = bit_q + 4'd1;
        tx_d  = {tx_q[6:0], 1'b0};
        case (state_q)
          STA: begin
            state_d = ADR;
            bit_d   = '0;
            tx_d    = {addr_q, read_q};
          end
          STO: begin
            state_d = IDLE;
            end_d   = 1'b1;
          end
          default: if (bit_q == 4'd8) begin
            // End of the acknowledge bit: pick the next byte or stop early.
            bit_d   = '0;
            state_d = STO;
            if (state_q == RD) rdata_d = rx_q;
            else if (nack_q) ack_d = 1'b1;
            else if (state_q == ADR) begin
              state_d = read_q ? RD : W1;
              tx_d    = wd1_q;
            end else if (state_q == W1 && wlen_q) begin
              state_d = W2;
              tx_d    = wd2_q;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q   <= IDLE;
      qtr_q     <= '0;
      bit_q     <= '0;
      pend_q    <= 1'b0;
      nack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
      end_q     <= 1'b1;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q              <= state_d;
      qtr_q                <= qtr_d;
      bit_q                <= bit_d;
      pend_q               <= accept;
      end_q                <= end_d;
      ack_q                <= ack_d;
      rdata_q              <= rdata_d;
      {scl_q, sda_low_q}   <= bus_drive(state_d, qtr_d, bit_d, tx_d[7]);
      if (wrap && qtr_q == 2'd2 && bit_q == 4'd8) nack_q <= I2C_SDA;
    end
    tx_q <= tx_d;
    if (accept) begin
      addr_q <= I2C_ADDR;
      wlen_q <= I2C_WLEN;
      wd1_q  <= I2C_WDATA1;
      wd2_q  <= I2C_WDATA2;
      read_q <= READ;
    end
    if (state_q == RD && wrap && qtr_q == 2'd2 && bit_q < 4'd8)
      rx_q <= {rx_q[6:0], I2C_SDA};
  end

  assign I2C_SCL   = scl_q;
  assign I2C_SDA   = sda_low_q ? 1'b0 : 1'bz;
  assign END       = end_q;
  assign ACK       = ack_q;
  assign I2C_RDATA = rdata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: directed and random transactions against a bus-level
// slave responder and a transaction-level expectation model.
module tb_i2c_master;

  localparam int         CLK_F = 400;
  localparam int         SCL_F = 25;
  localparam int         DIV   = 4;
  localparam logic [6:0] SLV   = 7'h39;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       I2C_SCL;
  wire        I2C_SDA;
  logic [6:0] I2C_ADDR = '0;
  logic       I2C_WLEN = 1'b0;
  logic [7:0] I2C_WDATA1 = '0;
  logic [7:0] I2C_WDATA2 = '0;
  logic       READ = 1'b0;
  logic       START = 1'b0;
  logic       END, ACK;
  logic [7:0] I2C_RDATA;

  logic       sl_drv = 1'b0;
  pullup (I2C_SDA);
  assign I2C_SDA = sl_drv ? 1'b0 : 1'bz;

  always #5 iCLK = ~iCLK;

  i2c_master #(.CLK_Freq(CLK_F), .I2C_Freq(SCL_F)) dut (
    .iCLK       (iCLK),
    .iRST_N     (iRST_N),
    .I2C_SCL    (I2C_SCL),
    .I2C_SDA    (I2C_SDA),
    .I2C_ADDR   (I2C_ADDR),
    .I2C_WLEN   (I2C_WLEN),
    .I2C_WDATA1 (I2C_WDATA1),
    .I2C_WDATA2 (I2C_WDATA2),
    .READ       (READ),
    .START      (START),
    .END        (END),
    .ACK        (ACK),
    .I2C_RDATA  (I2C_RDATA)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] exp_rdata = 8'h00;

  // Slave responder state and the bytes it saw the master write.
  logic       s_scl, s_sda;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  logic       active = 1'b0, rdm = 1'b0, adr_ok = 1'b0, mack = 1'b0;
  int         bitn = 0, byten = 0;
  logic [7:0] sh = '0;
  logic [7:0] slv_rd_val = '0;
  int         slv_nack_idx = 0;
  logic [7:0] bus_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge iCLK);
      s_scl = I2C_SCL;
      s_sda = I2C_SDA;
      if (!iRST_N) begin
        active = 1'b0;
        sl_drv = 1'b0;
      end else if (scl_p && s_scl && sda_p && !s_sda) begin
        active = 1'b1; bitn = 0; byten = 0; rdm = 1'b0; adr_ok = 1'b0; sl_drv = 1'b0;
      end else if (scl_p && s_scl && !sda_p && s_sda) begin
        active = 1'b0;
        sl_drv = 1'b0;
      end else if (active && !scl_p && s_scl) begin
        if (bitn < 8) sh = {sh[6:0], s_sda};
        else          mack = s_sda;
        bitn++;
      end else if (active && scl_p && !s_scl) begin
        if (bitn == 8) begin
          if (rdm) begin
            sl_drv = 1'b0;
            rdm    = 1'b0;
          end else begin
            bus_q.push_back(sh);
            if (byten == 0) begin
              adr_ok = (sh[7:1] == SLV);
              rdm    = adr_ok && sh[0];
              sl_drv = adr_ok;
            end else begin
              sl_drv = (byten != slv_nack_idx);
            end
            byten++;
          end
        end else if (bitn == 9) begin
          bitn   = 0;
          sl_drv = rdm ? ~slv_rd_val[7] : 1'b0;
        end else if (rdm && bitn >= 1 && bitn <= 7) begin
          sl_drv = ~slv_rd_val[7-bitn];
        end
      end
      scl_p = s_scl;
      sda_p = s_sda;
    end
  end

  task automatic check_reset_state(input string pfx);
    check({pfx, "_scl"},   I2C_SCL,   1);
    check({pfx, "_sda"},   I2C_SDA,   1);
    check({pfx, "_end"},   END,       1);
    check({pfx, "_ack"},   ACK,       0);
    check({pfx, "_rdata"}, I2C_RDATA, 0);
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_txn(input logic [6:0] a, input logic wl, input logic [7:0] d1,
                         input logic [7:0] d2, input logic rd, input logic [7:0] rv,
                         input int nk, input bit pulse, input int rst_at);
    logic [7:0] eb[$];
    logic       eack;
    int         q, n;
    bit         done;
    // Expected bus bytes, duration in quarters and status.
    eb.push_back({a, rd});
    eack = 1'b0;
    q    = 4 + 36 + 4;
    if (a != SLV) eack = 1'b1;
    else if (rd) begin
      q         = 80;
      exp_rdata = rv;
    end else begin
      eb.push_back(d1);
      q = 80;
      if (nk == 1) eack = 1'b1;
      else if (wl) begin
        eb.push_back(d2);
        q = 116;
        if (nk == 2) eack = 1'b1;
      end
    end
    bus_q.delete();
    slv_rd_val   = rv;
    slv_nack_idx = nk;
    mack         = 1'b0;
    I2C_ADDR = a; I2C_WLEN = wl; I2C_WDATA1 = d1; I2C_WDATA2 = d2; READ = rd;
    START = 1'b1;
    @(posedge iCLK); #1;
    START      = 1'b0;
    I2C_ADDR   = 7'($urandom);
    I2C_WLEN   = 1'($urandom);
    I2C_WDATA1 = 8'($urandom);
    I2C_WDATA2 = 8'($urandom);
    READ       = 1'($urandom);
    n    = 0;
    done = 1'b0;
    while (!done && n < 1000) begin
      @(posedge iCLK); #1;
      n++;
      if (n == 1) check("end_busy", END, 0);
      if (pulse && n == 100) begin
        START      = 1'b1;
        I2C_WDATA1 = ~d1;
      end
      if (pulse && n == 101) START = 1'b0;
      if (rst_at > 0 && n == rst_at) iRST_N = 1'b0;
      if (rst_at > 0 && n == rst_at + 1) begin
        check_reset_state("midrst");
        iRST_N    = 1'b1;
        exp_rdata = 8'h00;
        return;
      end
      done = END;
    end
    check("end_seen", done, 1);
    check("end_cycle", n, 1 + q * DIV);
    check("ack", ACK, eack);
    check("rdata", I2C_RDATA, exp_rdata);
    check("nbytes", bus_q.size(), eb.size());
    for (int k = 0; k < eb.size() && k < bus_q.size(); k++)
      check("bus_byte", bus_q[k], eb[k]);
    if (rd && a == SLV) check("master_nack", mack, 1);
    if (pulse) begin
      repeat (3) @(posedge iCLK);
      #1;
      check("stay_idle", END, 1);
    end
  endtask

  initial begin
    logic [6:0] ra;
    iRST_N = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    check_reset_state("rst");
    iRST_N = 1'b1;
    @(posedge iCLK); #1;

    run_txn(SLV,   1'b1, 8'h98, 8'h03, 1'b0, 8'h00, 0, 1'b0, 0);
    run_txn(7'h3A, 1'b1, 8'h55, 8'h66, 1'b0, 8'h00, 0, 1'b0, 0);
    run_txn(SLV,   1'b0, 8'h00, 8'h00, 1'b1, 8'hA5, 0, 1'b0, 0);
    run_txn(SLV,   1'b0, 8'h41, 8'h77, 1'b0, 8'h00, 1, 1'b0, 0);
    run_txn(SLV,   1'b1, 8'h98, 8'h03, 1'b0, 8'h00, 0, 1'b1, 0);
    run_txn(SLV,   1'b1, 8'h98, 8'h03, 1'b0, 8'h00, 0, 1'b0, 40);
    run_txn(SLV,   1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 0, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = ($urandom_range(0, 1) != 0) ? SLV : 7'($urandom);
      run_txn(ra, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              8'($urandom), int'($urandom_range(0, 2)), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
